// File: rtl/y_signature.sv
// y_signature: folds each 501-bit DUT output sample to 32 bits and
// accumulates it into a MISR over a start-triggered capture window,
// then flags whether the final signature equals a reference value.
module y_signature #(
    parameter int          Y_WIDTH = 501,
    parameter int          SETTLE  = 2,
    parameter logic [31:0] POLY    = 32'h04C11DB7,
    parameter logic [31:0] SEED    = 32'hFFFFFFFF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [Y_WIDTH-1:0] y,
    input  logic               start,
    input  logic [15:0]        len,
    input  logic [31:0]        expected,
    output logic               busy,
    output logic               done,
    output logic               sig_valid,
    output logic [31:0]        signature,
    output logic               match
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_ACCUM,
        S_DONE
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [15:0] len_q;
    logic [15:0] cnt;
    logic [7:0]  settle_cnt;
    logic [31:0] fold_w;
    logic [31:0] misr_nx;

    // Zero-extend the sample to 512 bits and XOR its sixteen 32-bit words.
    function automatic logic [31:0] fold(input logic [Y_WIDTH-1:0] v);
        logic [511:0] ext;
        logic [31:0]  f;
        ext = 512'(v);
        f   = '0;
        for (int i = 0; i < 16; i++) begin
            f ^= ext[32*i +: 32];
        end
        return f;
    endfunction

    // Combinational MISR step for the sample currently on y.
    always_comb begin
        fold_w  = fold(y);
        misr_nx = {signature[30:0], 1'b0} ^ (signature[31] ? POLY : 32'h0) ^ fold_w;
    end

    // Next-state logic; the last settle edge or last sample edge leaves its
    // state directly so DONE lines up with the final MISR update.
    // NOTE: state_nx gets a default before the case so no path infers a latch.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (SETTLE > 0)       state_nx = S_SETTLE;
                    else if (len != '0)   state_nx = S_ACCUM;
                    else                  state_nx = S_DONE;
                end
            end
            S_SETTLE: begin
                if (settle_cnt == 8'(SETTLE - 1))
                    state_nx = (len_q == '0) ? S_DONE : S_ACCUM;
            end
            S_ACCUM: begin
                if (cnt == len_q - 16'd1) state_nx = S_DONE;
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Window datapath: length latch, counters, MISR, result flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q      <= '0;
            cnt        <= '0;
            settle_cnt <= '0;
            signature  <= SEED;
            sig_valid  <= 1'b0;
            match      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        len_q      <= len;
                        cnt        <= '0;
                        settle_cnt <= '0;
                        signature  <= SEED;
                        sig_valid  <= 1'b0;
                        match      <= 1'b0;
                    end
                end
                S_SETTLE: settle_cnt <= settle_cnt + 8'd1;
                S_ACCUM: begin
                    signature <= misr_nx;
                    cnt       <= cnt + 16'd1;
                end
                // Compare is taken in DONE, so match is valid from the
                // cycle after the done pulse onwards.
                S_DONE:   match <= (signature == expected);
                default: ;
            endcase
            // Placed after the case so a zero-length window that starts and
            // finishes on the same edge still ends with sig_valid set.
            if (state != S_DONE && state_nx == S_DONE) sig_valid <= 1'b1;
        end
    end

    assign busy = (state == S_SETTLE) || (state == S_ACCUM);
    assign done = (state == S_DONE);

endmodule
